seven_segment_reader: RTL and testbench

Recovers hex digit values from a multiplexed seven-segment display bus (segments a–g plus per-digit enables), the inverse of the segment decoder that drives the parking-lot occupancy displays. It sits beside the display pins:
- It filters scan transitions with a stability counter.
- It encodes each settled segment pattern back to a 4-bit code.
- It assembles complete multi-digit frames.

Self-check logic and the test harness use it to confirm the displayed free-slot count.

---
 rtl/seven_segment_reader.sv | 204 ++++++++++++++++++++
 tb/tb_seven_segment_reader.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/seven_segment_reader.sv
// seven_segment_reader: recovers hex digit codes and complete frames from a
// multiplexed seven-segment display bus (segments a..g plus one enable per digit).
// Optional feature macro: SEVEN_SEG_READER_DP_EN adds decimal-point capture
// (input i_dp, output o_dp). Undefined by default.
module seven_segment_reader #(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned STABLE_CYCLES = 8,
  parameter bit          COMMON_ANODE  = 1'b1
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [6:0]              i_segments,
  input  logic [NUM_DIGITS-1:0]   i_digit_en,
`ifdef SEVEN_SEG_READER_DP_EN
  input  logic                    i_dp,
  output logic [NUM_DIGITS-1:0]   o_dp,
`endif
  output logic [4*NUM_DIGITS-1:0] o_digits,
  output logic [NUM_DIGITS-1:0]   o_digit_valid,
  output logic [4*NUM_DIGITS-1:0] o_frame,
  output logic                    o_frame_valid,
  output logic                    o_pattern_err,
  output logic                    o_glitch
);

`ifdef SEVEN_SEG_READER_DP_EN
  localparam int unsigned DP_W = 1;
`else
  localparam int unsigned DP_W = 0;
`endif
  localparam int unsigned BUS_W = DP_W + NUM_DIGITS + 7;
  localparam int unsigned CNT_W = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [BUS_W-1:0] POL_MASK = COMMON_ANODE ? {BUS_W{1'b1}} : {BUS_W{1'b0}};

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_HELD} state_t;

  logic [BUS_W-1:0]        w_pins;
  logic [BUS_W-1:0]        r_sync1;
  logic [BUS_W-1:0]        r_sync2;
  logic [BUS_W-1:0]        r_cmp;
  logic                    r_chg;
  logic [6:0]              w_seg;
  logic [NUM_DIGITS-1:0]   w_en;
  logic                    w_onehot;
  logic                    w_multi;
  logic [3:0]              w_code;
  logic                    w_legal;
  logic                    w_blank;
  logic [4*NUM_DIGITS-1:0] w_digits_next;
  logic [NUM_DIGITS-1:0]   w_seen_next;

  state_t                  r_state;
  logic [CNT_W-1:0]        r_cnt;
  logic [NUM_DIGITS-1:0]   r_seen;
  logic [4*NUM_DIGITS-1:0] r_digits;
  logic [NUM_DIGITS-1:0]   r_valid;
  logic [4*NUM_DIGITS-1:0] r_frame;
  logic                    r_frame_valid;
  logic                    r_pattern_err;
  logic                    r_glitch;

`ifdef SEVEN_SEG_READER_DP_EN
  logic                    w_dp;
  logic [NUM_DIGITS-1:0]   r_dp;
  assign w_pins = {i_dp, i_digit_en, i_segments};
  assign w_dp   = r_cmp[BUS_W-1];
  assign o_dp   = r_dp;
`else
  assign w_pins = {i_digit_en, i_segments};
`endif

  assign w_seg    = r_cmp[6:0];
  assign w_en     = r_cmp[7 +: NUM_DIGITS];
  assign w_onehot = (w_en != '0) && ((w_en & (w_en - NUM_DIGITS'(1))) == '0);
  assign w_multi  = (w_en != '0) && !w_onehot;
  assign w_blank  = (w_seg == 7'h00);
  assign w_seen_next = r_seen | w_en;

  assign o_digits      = r_digits;
  assign o_digit_valid = r_valid;
  assign o_frame       = r_frame;
  assign o_frame_valid = r_frame_valid;
  assign o_pattern_err = r_pattern_err;
  assign o_glitch      = r_glitch;

  // Synchronise the (polarity-normalised) bus, keep a compare copy and flag changes
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_cmp   <= '0;
      r_chg   <= 1'b0;
    end else begin
      r_sync1 <= w_pins ^ POL_MASK;
      r_sync2 <= r_sync1;
      r_cmp   <= r_sync2;
      r_chg   <= (r_sync2 != r_cmp);
    end
  end

  // Inverse of the standard hex segment table
  always_comb begin
    w_code  = 4'h0;
    w_legal = 1'b1;
    case (w_seg)
      7'h3F: w_code = 4'h0;
      7'h06: w_code = 4'h1;
      7'h5B: w_code = 4'h2;
      7'h4F: w_code = 4'h3;
      7'h66: w_code = 4'h4;
      7'h6D: w_code = 4'h5;
      7'h7D: w_code = 4'h6;
      7'h07: w_code = 4'h7;
      7'h7F: w_code = 4'h8;
      7'h6F: w_code = 4'h9;
      7'h77: w_code = 4'hA;
      7'h7C: w_code = 4'hB;
      7'h39: w_code = 4'hC;
      7'h5E: w_code = 4'hD;
      7'h79: w_code = 4'hE;
      7'h71: w_code = 4'hF;
      default: w_legal = 1'b0;
    endcase
  end

  // Digit vector as it would look after capturing into the enabled slot
  always_comb begin
    w_digits_next = r_digits;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (w_en[k]) w_digits_next[4*k +: 4] = w_legal ? w_code : 4'h0;
    end
  end

  // Settle FSM, capture and frame assembly
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_seen        <= '0;
      r_digits      <= '0;
      r_valid       <= '0;
      r_frame       <= '0;
      r_frame_valid <= 1'b0;
      r_pattern_err <= 1'b0;
      r_glitch      <= 1'b0;
`ifdef SEVEN_SEG_READER_DP_EN
      r_dp          <= '0;
`endif
    end else begin
      r_frame_valid <= 1'b0;
      r_pattern_err <= 1'b0;
      r_glitch      <= 1'b0;
      if (w_multi) begin
        r_glitch <= 1'b1;
        r_state  <= S_IDLE;
        r_cnt    <= '0;
      end else if (!w_onehot) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_state <= S_SETTLE;
            r_cnt   <= '0;
          end
          S_SETTLE: begin
            if (r_chg) begin
              r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
              r_state  <= S_HELD;
              r_digits <= w_digits_next;
              r_valid  <= w_legal ? (r_valid | w_en) : (r_valid & ~w_en);
              if (!w_legal && !w_blank) r_pattern_err <= 1'b1;
`ifdef SEVEN_SEG_READER_DP_EN
              r_dp <= w_dp ? (r_dp | w_en) : (r_dp & ~w_en);
`endif
              if (&w_seen_next) begin
                r_frame       <= w_digits_next;
                r_frame_valid <= 1'b1;
                r_seen        <= '0;
              end else begin
                r_seen <= w_seen_next;
              end
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          S_HELD: begin
            if (r_chg) begin
              r_state <= S_SETTLE;
              r_cnt   <= '0;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seven_segment_reader.sv
// Scoreboard bench for seven_segment_reader (NUM_DIGITS=4, STABLE_CYCLES=8, common anode).
module tb_seven_segment_reader;
  localparam int unsigned ND  = 4;
  localparam int unsigned SC  = 8;
  localparam int          LAT  = SC + 4;  // drive cycle -> cycle count seen at following negedge
  localparam int          GLAT = 4;

  typedef enum int {EV_DIGITS, EV_ERR, EV_FRAME, EV_GLITCH} ev_kind_t;
  typedef struct {
    string       name;
    ev_kind_t    kind;
    int          due;
    logic [31:0] data;
  } ev_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [6:0]      i_segments;
  logic [ND-1:0]   i_digit_en;
  logic [4*ND-1:0] o_digits;
  logic [ND-1:0]   o_digit_valid;
  logic [4*ND-1:0] o_frame;
  logic            o_frame_valid;
  logic            o_pattern_err;
  logic            o_glitch;
`ifdef SEVEN_SEG_READER_DP_EN
  logic [ND-1:0]   o_dp;
`endif

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  ev_t  exp_q[$];
  logic [19:0] prev_dv = '0;
  logic [19:0] cur_dv;

  seven_segment_reader #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC), .COMMON_ANODE(1'b1)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_segments    (i_segments),
    .i_digit_en    (i_digit_en),
`ifdef SEVEN_SEG_READER_DP_EN
    .i_dp          (1'b1),
    .o_dp          (o_dp),
`endif
    .o_digits      (o_digits),
    .o_digit_valid (o_digit_valid),
    .o_frame       (o_frame),
    .o_frame_valid (o_frame_valid),
    .o_pattern_err (o_pattern_err),
    .o_glitch      (o_glitch)
  );

  always #5 clk = ~clk;

  // Free-running cycle counter used to time expected events
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push(input string name, input ev_kind_t kind, input int due, input logic [31:0] data);
    ev_t e;
    e.name = name; e.kind = kind; e.due = due; e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic push_digits(input string name, input logic [15:0] digits, input logic [3:0] valid, input int due);
    push(name, EV_DIGITS, due, {12'h0, valid, digits});
  endtask

  task automatic check_ev(input ev_kind_t kind, input logic [31:0] data);
    ev_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got kind=%0d data=%h at cycle %0d, expected no event", kind, data, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.due != cyc || e.data !== data) begin
        n_fail++;
        $display("FAIL %s: got kind=%0d cycle=%0d data=%h, expected kind=%0d cycle=%0d data=%h",
                 e.name, kind, cyc, data, e.kind, e.due, e.data);
      end
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_digits"}, 32'(o_digits), 32'h0);
    chk({tag, "_digit_valid"}, 32'(o_digit_valid), 32'h0);
    chk({tag, "_frame"}, 32'(o_frame), 32'h0);
    chk({tag, "_frame_valid"}, 32'(o_frame_valid), 32'h0);
    chk({tag, "_pattern_err"}, 32'(o_pattern_err), 32'h0);
    chk({tag, "_glitch"}, 32'(o_glitch), 32'h0);
  endtask

  // Drive the pins from active-high values (common anode inverts at the pins)
  task automatic drive(input logic [3:0] en, input logic [6:0] seg);
    i_digit_en = ~en;
    i_segments = ~seg;
  endtask

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an observable event
  always @(negedge clk) begin
    cur_dv = {o_digit_valid, o_digits};
    if (!rst_n) begin
      prev_dv = cur_dv;
    end else begin
      if (cur_dv != prev_dv) begin
        check_ev(EV_DIGITS, {12'h0, cur_dv});
        prev_dv = cur_dv;
      end
      if (o_pattern_err) check_ev(EV_ERR, 32'h0);
      if (o_frame_valid) check_ev(EV_FRAME, {16'h0, o_frame});
      if (o_glitch)      check_ev(EV_GLITCH, 32'h0);
    end
  end

  // Stimulus
  initial begin
    int n0;
    rst_n = 1'b0;
    drive(4'b0000, 7'h00);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("reset_init");
    @(posedge clk); #1;
    rst_n = 1'b1;
    hold(4);

    // Single digit 0 showing 2
    n0 = cyc; drive(4'b0001, 7'h5B);
    push_digits("single_d0_2", 16'h0002, 4'b0001, n0 + LAT);
    hold(20); drive(4'b0000, 7'h00); hold(5);

    // Full frame 1,2,3,4
    n0 = cyc; drive(4'b0001, 7'h06); push_digits("frame_d0_1", 16'h0001, 4'b0001, n0 + LAT); hold(16);
    n0 = cyc; drive(4'b0010, 7'h5B); push_digits("frame_d1_2", 16'h0021, 4'b0011, n0 + LAT); hold(16);
    n0 = cyc; drive(4'b0100, 7'h4F); push_digits("frame_d2_3", 16'h0321, 4'b0111, n0 + LAT); hold(16);
    n0 = cyc; drive(4'b1000, 7'h66); push_digits("frame_d3_4", 16'h4321, 4'b1111, n0 + LAT);
    push("frame_4321", EV_FRAME, n0 + LAT, 32'h0000_4321); hold(16);
    drive(4'b0000, 7'h00); hold(5);

    // Digit 0 at 5, then a 5-cycle flash of 8 that must not capture
    n0 = cyc; drive(4'b0001, 7'h6D); push_digits("short_d0_5", 16'h4325, 4'b1111, n0 + LAT); hold(20);
    drive(4'b0001, 7'h7F); hold(5);
    drive(4'b0001, 7'h6D); hold(20);
    drive(4'b0000, 7'h00); hold(5);

    // Two enables active for 10 cycles
    n0 = cyc; drive(4'b0011, 7'h6D);
    for (int i = 0; i < 10; i++) push("multi_hot_glitch", EV_GLITCH, n0 + GLAT + i, 32'h0);
    hold(10); drive(4'b0000, 7'h00); hold(8);

    // Illegal pattern, legal 7, blank on digit 2; then complete a frame
    n0 = cyc; drive(4'b0100, 7'h01); push_digits("bad_d2_digits", 16'h4025, 4'b1011, n0 + LAT);
    push("bad_d2_err", EV_ERR, n0 + LAT, 32'h0); hold(16);
    n0 = cyc; drive(4'b0100, 7'h07); push_digits("d2_7", 16'h4725, 4'b1111, n0 + LAT); hold(16);
    n0 = cyc; drive(4'b0100, 7'h00); push_digits("blank_d2", 16'h4025, 4'b1011, n0 + LAT); hold(16);
    n0 = cyc; drive(4'b0010, 7'h6F); push_digits("d1_9", 16'h4095, 4'b1011, n0 + LAT); hold(16);
    n0 = cyc; drive(4'b1000, 7'h77); push_digits("d3_A", 16'hA095, 4'b1011, n0 + LAT);
    push("frame_A095", EV_FRAME, n0 + LAT, 32'h0000_A095); hold(16);
    drive(4'b0000, 7'h00); hold(5);

    // Reset while the counter is at 5, then capture after release
    n0 = cyc; drive(4'b0010, 7'h4F);
    hold(9);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset("reset_mid");
    hold(2);
    chk("reset_mid_held_digits", 32'(o_digits), 32'h0);
    rst_n = 1'b1;
    n0 = cyc;
    push_digits("after_reset_d1_3", 16'h0030, 4'b0010, n0 + LAT);
    hold(20); drive(4'b0000, 7'h00); hold(5);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
